muladd2_dot_acc: RTL and testbench
==================================

MULADD2_DOT_ACC -- requirements
Module: muladd2_dot_acc

Interface
REQ-001 Parameter NPAIR, default 8: 8-bit pair lanes per input beat; legal range 1..64.
REQ-002 Parameter ACC_W, default 24: accumulator and result width, two's complement; legal range 8..32.
REQ-003 The single clock and the reset are fixed.
- clk: one clock.
- rst: reset, synchronous, active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  beat present on in_data.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 in_data  input  8*NPAIR  lane k is bits [8k+7:8k], packed {a1[1:0],w1[1:0],a0[1:0],w0[1:0]}.
REQ-009 in_last  input  1  beat is the final beat of a frame.
REQ-010 in_mode  input  1  decode mode: 0 = 2-bit, 1 = 1-bit sign; sampled on the first beat of each frame.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  ACC_W  signed frame dot-product.
REQ-014 out_sat  output  1  saturation occurred at any point in this frame.
REQ-015 out_beats  output  16  beats in this frame; saturates at 65535.

Function
REQ-016 Mode 0 decode: 00→-3, 01→-1, 10→+1, 11→+3. Lane value = dec(a0)*dec(w0) + dec(a1)*dec(w1), range [-18,18].
REQ-017 Mode 1 decode: bit[1] of each code only; 0→-1, 1→+1. Lane value range [-2,2].
REQ-018 The frame's mode comes from in_mode on its first accepted beat; in_mode on later beats of the frame is ignored.
REQ-019 Beat sum = signed sum of all NPAIR lane values, computed exactly (no truncation).
REQ-020 Beat transfer occurs when in_valid and in_ready are both high; result transfer occurs when out_valid and out_ready are both high.
REQ-021 Pipeline stage S1 registers {beat sum, last, mode}. Stage S2 is the accumulator.
REQ-022 Latency: the last beat of a frame accepted in cycle T gives out_valid=1 in cycle T+2 when the output is free.
REQ-023 S1 stall: S1 shall stall while it holds a last beat and out_valid=1 and out_ready=0.
REQ-024 in_ready = !s1_valid || !(s1_last && out_valid && !out_ready); in_ready is combinational on out_ready.
REQ-025 Non-last beat leaving S1: acc ← sat(acc + beat_sum); beat counter increments.
REQ-026 Last beat leaving S1: out_data ← sat(acc + beat_sum), out_sat ← sticky_sat or this saturation, out_beats ← count+1, out_valid ← 1; acc, sticky_sat and counter clear to 0.
REQ-027 sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets sticky_sat for the frame.
REQ-028 Simultaneous result accept and new last beat leaving S1: the new result loads and out_valid stays 1 (no bubble).
REQ-029 out_data, out_sat and out_beats shall remain stable while out_valid=1 and out_ready=0.
REQ-030 A single-beat frame (first beat has in_last=1) is legal and yields out_beats=1.
REQ-031 in_data, in_last and in_mode are don't-care when in_valid=0. S1 and S2 hold their state across idle cycles.
REQ-032 Frame state: IDLE (counter=0) and ACCUM (counter>0). IDLE→ACCUM on a non-last beat leaving S1. ACCUM→IDLE on a last beat leaving S1.

Reset
REQ-033 Reset values: out_valid=0, out_data=0, out_sat=0, out_beats=0, s1_valid=0, acc=0, sticky_sat=0, counter=0, state IDLE.
REQ-034 in_ready=1 in the first cycle after rst deasserts.
REQ-035 Reset mid-frame discards the partial accumulation and any pending result; no out_valid for that frame.

Verification (NPAIR=4 unless noted)
REQ-036 Mode 0, one beat of 32'hFFFFFFFF with last=1 accepted in cycle T → out_valid in T+2, out_data=72, out_beats=1, out_sat=0.
REQ-037 Mode 0, frame {32'hFFFFFFFF, 32'h33333333 last} → out_data=0, out_beats=2.
REQ-038 Mode 1, three beats of 32'hFFFFFFFF, last on the third → out_data=24; in_mode=0 driven on beats 2-3 has no effect.
REQ-039 ACC_W=8, mode 0, two beats of 32'hFFFFFFFF → out_data=127, out_sat=1; the next frame of 32'h33333333 (one beat) → out_data=-72, out_sat=0.
REQ-040 out_ready=0 held for 10 cycles while two single-beat frames are streamed back-to-back → frame 1 held stable, in_ready drops; after out_ready=1 both results delivered in order with no loss.
REQ-041 rst pulsed after 2 of 3 beats, then a fresh single-beat frame of 32'hFFFFFFFF → exactly one result, out_data=72, out_beats=1.

Source files
------------

// File: rtl/muladd2_dot_acc.sv
// rtl/muladd2_dot_acc.sv - ternary/binary pair-lane dot-product accumulator
// Two-stage pipe: S1 holds the decoded beat sum, S2 accumulates frames with saturation.
module muladd2_dot_acc #(
    parameter int NPAIR = 8,
    parameter int ACC_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*NPAIR-1:0] in_data,
    input  logic               in_last,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic               out_sat,
    output logic [15:0]        out_beats
);

    // |beat sum| <= 18*64 = 1152, fits a 12-bit signed value
    localparam int SUM_W = 12;
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic logic signed [SUM_W-1:0] dec2(input logic [1:0] c);
        logic signed [SUM_W-1:0] r;
        case (c)
            2'b00:   r = -12'sd3;
            2'b01:   r = -12'sd1;
            2'b10:   r = 12'sd1;
            default: r = 12'sd3;
        endcase
        return r;
    endfunction

    function automatic logic signed [SUM_W-1:0] dec1(input logic b);
        return b ? 12'sd1 : -12'sd1;
    endfunction

    logic                    s1_valid;
    logic                    s1_last;
    logic signed [SUM_W-1:0] s1_sum;
    logic                    first_beat;
    logic                    frame_mode;
    logic                    eff_mode;
    logic signed [SUM_W-1:0] beat_sum;
    logic                    accept;
    logic                    s1_go;

    logic signed [ACC_W-1:0] acc;
    logic                    sticky_sat;
    logic [15:0]             beat_cnt;
    logic [15:0]             beats_inc;
    logic signed [EXT_W-1:0] raw_sum;
    logic [EXT_W-ACC_W:0]    raw_top;
    logic                    sat_hit;
    logic signed [ACC_W-1:0] sat_val;
    state_t                  state, state_next;

    // Mode is latched on the first beat; later beats of the frame reuse it
    assign eff_mode = first_beat ? in_mode : frame_mode;

    always_comb begin : beat_decode
        logic signed [SUM_W-1:0] da1, dw1, da0, dw0;
        beat_sum = '0;
        for (int k = 0; k < NPAIR; k++) begin
            if (eff_mode) begin
                da1 = dec1(in_data[8*k+7]);
                dw1 = dec1(in_data[8*k+5]);
                da0 = dec1(in_data[8*k+3]);
                dw0 = dec1(in_data[8*k+1]);
            end else begin
                da1 = dec2(in_data[8*k+6 +: 2]);
                dw1 = dec2(in_data[8*k+4 +: 2]);
                da0 = dec2(in_data[8*k+2 +: 2]);
                dw0 = dec2(in_data[8*k+0 +: 2]);
            end
            beat_sum = beat_sum + da1 * dw1 + da0 * dw0;
        end
    end

    // A last beat may not leave S1 while the previous result is still unconsumed
    assign s1_go    = s1_valid && !(s1_last && out_valid && !out_ready);
    assign in_ready = !s1_valid || !(s1_last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_sum     <= '0;
            first_beat <= 1'b1;
            frame_mode <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_last    <= in_last;
            s1_sum     <= beat_sum;
            first_beat <= in_last;
            if (first_beat) begin
                frame_mode <= in_mode;
            end
        end else if (s1_go) begin
            s1_valid <= 1'b0;
        end
    end

    // Overflow when the bits above the accumulator sign bit disagree with it
    assign raw_sum = {{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc}
                   + {{(EXT_W-SUM_W){s1_sum[SUM_W-1]}}, s1_sum};
    assign raw_top = raw_sum[EXT_W-1:ACC_W-1];
    assign sat_hit = !((&raw_top) || !(|raw_top));
    assign sat_val = !sat_hit ? raw_sum[ACC_W-1:0]
                   : raw_sum[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                   : {1'b0, {(ACC_W-1){1'b1}}};
    assign beats_inc = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;

    always_comb begin
        state_next = state;
        if (s1_go) begin
            state_next = s1_last ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            sticky_sat <= 1'b0;
            beat_cnt   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sat    <= 1'b0;
            out_beats  <= '0;
        end else begin
            state <= state_next;
            if (s1_go && !s1_last) begin
                acc        <= sat_val;
                sticky_sat <= sticky_sat | sat_hit;
                beat_cnt   <= beats_inc;
            end else if (s1_go && s1_last) begin
                acc        <= '0;
                sticky_sat <= 1'b0;
                beat_cnt   <= '0;
            end
            if (s1_go && s1_last) begin
                out_valid <= 1'b1;
                out_data  <= sat_val;
                out_sat   <= sticky_sat | sat_hit;
                out_beats <= beats_inc;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muladd2_dot_acc.sv
// tb/tb_muladd2_dot_acc.sv - scoreboard bench for muladd2_dot_acc at ACC_W 24 and 8
module tb_muladd2_dot_acc;

    localparam int NP = 4;

    typedef struct {
        longint data;
        bit     sat;
        longint beats;
    } res_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_mode;
    logic        out_ready;
    logic        in_ready_a, in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic [23:0] out_data_a;
    logic [7:0]  out_data_b;
    logic        out_sat_a, out_sat_b;
    logic [15:0] out_beats_a, out_beats_b;

    muladd2_dot_acc #(.NPAIR(NP), .ACC_W(24)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .in_mode(in_mode),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_sat(out_sat_a), .out_beats(out_beats_a)
    );

    muladd2_dot_acc #(.NPAIR(NP), .ACC_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .in_mode(in_mode),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_sat(out_sat_b), .out_beats(out_beats_b)
    );

    res_t   q24[$];
    res_t   q8[$];
    longint m_acc24, m_acc8;
    bit     m_sat24, m_sat8;
    longint m_cnt;
    bit     m_first;
    bit     m_mode;
    int     n_tests;
    int     n_fail;
    int     n_rx;
    int     rdy_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint dec2(input bit [1:0] c);
        case (c)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b10:   return 1;
            default: return 3;
        endcase
    endfunction

    function automatic longint sgn(input bit b);
        return b ? 1 : -1;
    endfunction

    function automatic longint lane_val(input bit [7:0] l, input bit mode);
        if (mode) return sgn(l[7]) * sgn(l[5]) + sgn(l[3]) * sgn(l[1]);
        return dec2(l[7:6]) * dec2(l[5:4]) + dec2(l[3:2]) * dec2(l[1:0]);
    endfunction

    function automatic longint clampw(input longint v, input int w, output bit hit);
        longint hi, lo;
        hi  = (longint'(1) << (w - 1)) - 1;
        lo  = -(longint'(1) << (w - 1));
        hit = (v > hi) || (v < lo);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_reset();
        m_acc24 = 0; m_acc8 = 0; m_sat24 = 0; m_sat8 = 0;
        m_cnt = 0; m_first = 1; m_mode = 0;
        q24.delete(); q8.delete();
    endtask

    task automatic model_beat(input bit [31:0] d, input bit last, input bit mode);
        longint bs, v24, v8;
        bit h24, h8;
        res_t r;
        if (m_first) m_mode = mode;
        bs = 0;
        for (int k = 0; k < NP; k++) bs += lane_val(d[8*k +: 8], m_mode);
        v24 = clampw(m_acc24 + bs, 24, h24);
        v8  = clampw(m_acc8 + bs, 8, h8);
        if (last) begin
            r.data = v24; r.sat = m_sat24 | h24; r.beats = m_cnt + 1;
            q24.push_back(r);
            r.data = v8;  r.sat = m_sat8 | h8;   r.beats = m_cnt + 1;
            q8.push_back(r);
            m_acc24 = 0; m_acc8 = 0; m_sat24 = 0; m_sat8 = 0; m_cnt = 0;
            m_first = 1;
        end else begin
            m_acc24 = v24; m_acc8 = v8;
            m_sat24 |= h24; m_sat8 |= h8;
            m_cnt++;
            m_first = 0;
        end
    endtask

    task automatic send_beat(input bit [31:0] d, input bit last, input bit mode);
        bit ok;
        ok = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; in_mode = mode;
        for (int i = 0; i < 300; i++) begin
            #4;
            if (in_ready_a) begin
                ok = 1;
                model_beat(d, last, mode);
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        #1 in_valid = 1'b0;
        if (!ok) check_eq("in_ready_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && (q24.size() != 0 || q8.size() != 0); i++) @(negedge clk);
        check_eq("drain_q24_empty", q24.size(), 0);
        check_eq("drain_q8_empty", q8.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Every cycle a result is presented it must match the scoreboard head (covers hold stability)
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_a) begin
                if (q24.size() == 0) check_eq("a_spurious_result", 1, 0);
                else begin
                    check_eq("a_out_data", $signed(out_data_a), q24[0].data);
                    check_eq("a_out_sat", out_sat_a, q24[0].sat);
                    check_eq("a_out_beats", out_beats_a, q24[0].beats);
                    if (out_ready) begin
                        void'(q24.pop_front());
                        n_rx++;
                    end
                end
            end
            if (out_valid_b) begin
                if (q8.size() == 0) check_eq("b_spurious_result", 1, 0);
                else begin
                    check_eq("b_out_data", $signed(out_data_b), q8[0].data);
                    check_eq("b_out_sat", out_sat_b, q8[0].sat);
                    check_eq("b_out_beats", out_beats_b, q8[0].beats);
                    if (out_ready) void'(q8.pop_front());
                end
            end
        end
    end

    initial begin
        int rx0;
        n_tests = 0; n_fail = 0; n_rx = 0; rdy_mode = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_mode = 1'b0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready_a, 1);
        check_eq("rst_out_valid", out_valid_a, 0);
        check_eq("rst_out_data", out_data_a, 0);
        check_eq("rst_out_sat", out_sat_a, 0);
        check_eq("rst_out_beats", out_beats_a, 0);

        // single-beat frame and two-cycle latency
        send_beat(32'hFFFFFFFF, 1, 0);
        @(negedge clk);
        check_eq("latency_t1_out_valid", out_valid_a, 0);
        @(negedge clk);
        check_eq("latency_t2_out_valid", out_valid_a, 1);
        check_eq("single_beat_data", $signed(out_data_a), 72);

        send_beat(32'hFFFFFFFF, 0, 0);
        send_beat(32'h33333333, 1, 0);

        send_beat(32'hFFFFFFFF, 0, 1);
        send_beat(32'hFFFFFFFF, 0, 0);
        send_beat(32'hFFFFFFFF, 1, 0);

        send_beat(32'hFFFFFFFF, 0, 0);
        send_beat(32'hFFFFFFFF, 1, 0);
        send_beat(32'h33333333, 1, 0);
        drain();

        // back-pressure: second result must wait in S1 and block the input
        rdy_mode = 1;
        @(posedge clk);
        #2;
        send_beat(32'hFFFFFFFF, 1, 0);
        send_beat(32'h33333333, 1, 0);
        repeat (10) @(negedge clk);
        #1;
        check_eq("stall_in_ready", in_ready_a, 0);
        check_eq("stall_out_valid", out_valid_a, 1);
        check_eq("stall_pending", q24.size(), 2);
        rdy_mode = 0;
        drain();

        // reset mid-frame discards partial accumulation
        send_beat(32'hFFFFFFFF, 0, 0);
        send_beat(32'hFFFFFFFF, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx0 = n_rx;
        send_beat(32'hFFFFFFFF, 1, 0);
        drain();
        repeat (5) @(negedge clk);
        check_eq("reset_one_result", n_rx - rx0, 1);

        // random frames under random back-pressure
        rdy_mode = 2;
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                send_beat($urandom, (b == len - 1), 1'($urandom_range(0, 1)));
            end
        end
        rdy_mode = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
